ex_mem_stage: RTL

//  Consumer end of the ID/EX register: executes the latched ID/EX fields (ALU, operand forwarding,

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/ex_mem_stage_alu32.sv | 36 +++
 rtl/ex_mem_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the EX/MEM slice: datapath defaults, ALU op codes
// and the control-bit bubble loaded on reset, flush or branch squash.
package pipeline_pkg;

   localparam int DEF_XLEN    = 32;
   localparam int DEF_RADDR_W = 5;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_write;
      logic pc_src;
   } mem_ctrl_t;

   localparam mem_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_stage_alu32.sv
// Combinational ALU: logic, add/sub, signed compare and shifts of b by shamt.
// Unknown op codes produce zero.
module alu32
   import pipeline_pkg::*;
#(
   parameter int W = DEF_XLEN
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [4:0]   shamt,
   input  logic [3:0]   op,
   output logic [W-1:0] y,
   output logic         zero
);

   // Select the operation result; add/sub wrap naturally at W bits
   always_comb begin
      y = '0;
      case (op)
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_ADD: y = a + b;
         ALU_XOR: y = a ^ b;
         ALU_SUB: y = a - b;
         ALU_SLT: y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL: y = b << shamt;
         ALU_SRL: y = b >> shamt;
         ALU_SRA: y = $signed(b) >>> shamt;
         ALU_NOR: y = ~(a | b);
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register. Operand forwarding from the
// MEM and WB stages is compiled in only when FWD_UNIT_EN is defined.
// Update priority: RST > FLUSH > STALL > (branch squash | load).
module ex_mem_stage
   import pipeline_pkg::*;
#(
   parameter int XLEN    = DEF_XLEN,
   parameter int RADDR_W = DEF_RADDR_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               STALL,
   input  logic               FLUSH,
   input  logic               RegWrite,
   input  logic               MemtoReg,
   input  logic               MemWrite,
   input  logic               Branch,
   input  logic               ALUSrc,
   input  logic               ALUSrc_shamt,
   input  logic               RegDst,
   input  logic [3:0]         ALUControl,
   input  logic [XLEN-1:0]    RD1,
   input  logic [XLEN-1:0]    RD2,
   input  logic [RADDR_W-1:0] Rs,
   input  logic [RADDR_W-1:0] Rt,
   input  logic [RADDR_W-1:0] Rd,
   input  logic [XLEN-1:0]    SignImm,
   input  logic [XLEN-1:0]    PCplus4,
   input  logic               WB_RegWrite,
   input  logic [RADDR_W-1:0] WB_WriteReg,
   input  logic [XLEN-1:0]    WB_Result,
   output logic               MEM_RegWrite,
   output logic               MEM_MemtoReg,
   output logic               MEM_MemWrite,
   output logic [XLEN-1:0]    MEM_ALUOut,
   output logic [XLEN-1:0]    MEM_WriteData,
   output logic [RADDR_W-1:0] MEM_WriteReg,
   output logic               MEM_PCSrc,
   output logic [XLEN-1:0]    MEM_BranchTarget
);

   logic [XLEN-1:0]    fwd_a;
   logic [XLEN-1:0]    fwd_b;
   logic [XLEN-1:0]    alu_b;
   logic [4:0]         alu_shamt;
   logic [XLEN-1:0]    alu_y;
   logic               alu_zero;
   logic [RADDR_W-1:0] write_reg;
   logic [XLEN-1:0]    branch_target;
   logic               clear_now;

`ifdef FWD_UNIT_EN
   // A loaded value in MEM is not yet available, so only ALU results forward from MEM
   logic mem_fwd_ok;
   assign mem_fwd_ok = MEM_RegWrite & ~MEM_MemtoReg;

   assign fwd_a = (mem_fwd_ok && Rs != '0 && Rs == MEM_WriteReg) ? MEM_ALUOut :
                  (WB_RegWrite && Rs != '0 && Rs == WB_WriteReg)  ? WB_Result  : RD1;
   assign fwd_b = (mem_fwd_ok && Rt != '0 && Rt == MEM_WriteReg) ? MEM_ALUOut :
                  (WB_RegWrite && Rt != '0 && Rt == WB_WriteReg)  ? WB_Result  : RD2;
`else
   logic unused_wb;
   assign unused_wb = ^{WB_RegWrite, WB_WriteReg, WB_Result};

   assign fwd_a = RD1;
   assign fwd_b = RD2;
`endif

   // Immediate shifts always shift the register operand by the instruction's shamt field
   assign alu_b     = (ALUSrc_shamt || !ALUSrc) ? fwd_b : SignImm;
   assign alu_shamt = ALUSrc_shamt ? SignImm[10:6] : fwd_a[4:0];

   alu32 #(.W(XLEN)) u_alu (
      .a     (fwd_a),
      .b     (alu_b),
      .shamt (alu_shamt),
      .op    (ALUControl),
      .y     (alu_y),
      .zero  (alu_zero)
   );

   assign write_reg     = RegDst ? Rd : Rt;
   assign branch_target = PCplus4 + (SignImm << 2);

   // A taken branch in MEM turns the next unstalled load into a bubble
   assign clear_now = RST | FLUSH | (~STALL & MEM_PCSrc);

   // EX/MEM register: clear on reset/flush/squash, hold on stall, otherwise load
   always_ff @(posedge CLK) begin
      if (clear_now) begin
         {MEM_RegWrite, MEM_MemtoReg, MEM_MemWrite, MEM_PCSrc} <= CTRL_BUBBLE;
         MEM_ALUOut       <= '0;
         MEM_WriteData    <= '0;
         MEM_WriteReg     <= '0;
         MEM_BranchTarget <= '0;
      end else if (!STALL) begin
         MEM_RegWrite     <= RegWrite;
         MEM_MemtoReg     <= MemtoReg;
         MEM_MemWrite     <= MemWrite;
         MEM_PCSrc        <= Branch & alu_zero;
         MEM_ALUOut       <= alu_y;
         MEM_WriteData    <= fwd_b;
         MEM_WriteReg     <= write_reg;
         MEM_BranchTarget <= branch_target;
      end
   end

endmodule
